// File: rtl/hdmi_out_pkg.sv
// hdmi_out_pkg: default 720p timing, colour-bar table and FSM states for the HDMI output timing generator
package hdmi_out_pkg;
    localparam int DEF_DATA_W   = 24;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Bar 0 (leftmost) sits in the least significant slot
    localparam logic [8*24-1:0] BAR_TABLE = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                             BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};

    typedef enum logic {WAIT, RUN} state_e;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        return BAR_TABLE[int'(idx)*24 +: 24];
    endfunction
endpackage

// File: rtl/hdmi_delay_line.sv
// hdmi_delay_line: DEPTH-stage shift register that lines timing flags up with FIFO read data
module hdmi_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] pipe_d [DEPTH];
    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Each stage takes the previous one; stage 0 takes the new entry
    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Clear all stages on reset so no stale valid/de reaches the output
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/hdmi_out_timing_gen.sv
// hdmi_out_timing_gen: raster timing generator pulling pixels from the HDMI-out FIFO.
// Define HDMI_OUT_TEST_PATTERN_EN to add pattern_sel and an 8-bar colour test pattern.
module hdmi_out_timing_gen
    import hdmi_out_pkg::*;
#(
    parameter int   DATA_W     = DEF_DATA_W,
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              video_hs,
    output logic              video_vs,
    output logic              video_de,
    output logic [DATA_W-1:0] video_rgb,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr
`ifdef HDMI_OUT_TEST_PATTERN_EN
    ,
    input  logic              pattern_sel
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
`ifdef HDMI_OUT_TEST_PATTERN_EN
    localparam int TW = 10;
`else
    localparam int TW = 6;
`endif

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    state_e            state_q, state_d;
    logic              boundary, active0, hs0, vs0, fs0, run0, pat0;
    logic [TW-1:0]     tap_in, tap_out;
    logic              pat_dl, run_dl, valid_dl, de_dl, hs_dl, vs_dl, fs_dl;
    logic [DATA_W-1:0] pix;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, uf_q, uf_d;
    logic [DATA_W-1:0] rgb_q, rgb_d;
`ifdef HDMI_OUT_TEST_PATTERN_EN
    logic [2:0]        bar0, bar_dl;
`endif

    // Stage 0: raster position decode, frame-boundary state decision and FIFO read request
    always_comb begin
        boundary = (h_q == '0) && (v_q == '0);
        active0  = (h_q < H_ACT) && (v_q < V_ACT);
        hs0      = (h_q >= HS_BEG) && (h_q < HS_END);
        vs0      = (v_q >= VS_BEG) && (v_q < VS_END);
        run0     = boundary ? enable && (state_q == RUN || !fifo_rd_empty) : state_q == RUN;
        state_d  = run0 ? RUN : WAIT;
        fs0      = run0 && boundary;
        h_d      = (h_q == H_LAST) ? '0 : h_q + HW'(1);
        v_d      = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + VW'(1);
`ifdef HDMI_OUT_TEST_PATTERN_EN
        pat0     = pattern_sel;
        bar0     = 3'((32'(h_q) * 8) / H_ACTIVE);
`else
        pat0     = 1'b0;
`endif
        fifo_rd_en = !rst && run0 && active0 && !fifo_rd_empty && !pat0;
`ifdef HDMI_OUT_TEST_PATTERN_EN
        tap_in = {pat0, bar0, run0, fifo_rd_en, active0, hs0, vs0, fs0};
`else
        tap_in = {run0, fifo_rd_en, active0, hs0, vs0, fs0};
`endif
    end

    // Counters free-run from reset; state only changes on the frame boundary via run0
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            state_q <= WAIT;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            state_q <= state_d;
        end
    end

    hdmi_delay_line #(
        .WIDTH (TW),
        .DEPTH (RD_LATENCY)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tap_in),
        .dout (tap_out)
    );

    // Output stage: pick FIFO data, pattern or black and track the sticky underflow
    always_comb begin
`ifdef HDMI_OUT_TEST_PATTERN_EN
        {pat_dl, bar_dl, run_dl, valid_dl, de_dl, hs_dl, vs_dl, fs_dl} = tap_out;
        pix = pat_dl ? DATA_W'(bar_colour(bar_dl)) : valid_dl ? fifo_rd_data : '0;
`else
        {run_dl, valid_dl, de_dl, hs_dl, vs_dl, fs_dl} = tap_out;
        pat_dl = 1'b0;
        pix = valid_dl ? fifo_rd_data : '0;
`endif
        hs_d  = hs_dl ? HS_POL : !HS_POL;
        vs_d  = vs_dl ? VS_POL : !VS_POL;
        de_d  = de_dl;
        fs_d  = fs_dl;
        rgb_d = de_dl ? pix : '0;
        uf_d  = (de_dl && !valid_dl && run_dl && !pat_dl) || (uf_q && !underflow_clr);
    end

    // Registered video outputs, one cycle after the delay-line tap
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q  <= !HS_POL;
            vs_q  <= !VS_POL;
            de_q  <= 1'b0;
            rgb_q <= '0;
            fs_q  <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            rgb_q <= rgb_d;
            fs_q  <= fs_d;
            uf_q  <= uf_d;
        end
    end

    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign video_de    = de_q;
    assign video_rgb   = rgb_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;
endmodule

// File: tb/tb_hdmi_out_timing_gen.sv
// tb_hdmi_out_timing_gen: directed bench on a 14x7 raster with a two-cycle-latency FIFO model
module tb_hdmi_out_timing_gen;
    localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = 14, VT = 7, FT = 98;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, underflow_clr = 1'b0;
    logic        fifo_rd_en, fifo_rd_empty;
    logic [23:0] fifo_rd_data = '0;
    logic        video_hs, video_vs, video_de, frame_start, underflow;
    logic [23:0] video_rgb;
`ifdef HDMI_OUT_TEST_PATTERN_EN
    logic        pattern_sel = 1'b0;
`endif

    int          errors = 0, checks = 0;
    logic [23:0] mem [256];
    int          n_words = 0, rd_ptr = 0;
    logic        gap_en = 1'b0, tog = 1'b0;
    logic [23:0] d1 = '0;

    hdmi_out_timing_gen #(
        .DATA_W (24), .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL (1'b1), .VS_POL (1'b1), .RD_LATENCY (2)
    ) dut (
        .clk (clk), .rst (rst), .enable (enable),
        .fifo_rd_en (fifo_rd_en), .fifo_rd_data (fifo_rd_data), .fifo_rd_empty (fifo_rd_empty),
        .video_hs (video_hs), .video_vs (video_vs), .video_de (video_de), .video_rgb (video_rgb),
        .frame_start (frame_start), .underflow (underflow), .underflow_clr (underflow_clr)
`ifdef HDMI_OUT_TEST_PATTERN_EN
        , .pattern_sel (pattern_sel)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: registered output, data valid two cycles after the read strobe
    assign fifo_rd_empty = (rd_ptr >= n_words) || (gap_en && tog);
    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 0;
            tog <= 1'b0;
        end else begin
            tog <= ~tog;
            if (fifo_rd_en) begin
                rd_ptr <= rd_ptr + 1;
                d1 <= mem[rd_ptr];
            end
            fifo_rd_data <= d1;
        end
    end

    function automatic int hp(input int p); return p % HT; endfunction
    function automatic int vp(input int p); return (p / HT) % VT; endfunction
    function automatic logic act(input int p); return p >= 0 && hp(p) < HA && vp(p) < VA; endfunction
    function automatic logic hsx(input int p); return p >= 0 && hp(p) >= HA + HFP && hp(p) < HA + HFP + HSW; endfunction
    function automatic logic vsx(input int p); return p >= 0 && vp(p) >= VA + VFP && vp(p) < VA + VFP + VSW; endfunction
    // Frame-0 pixel ordinal when every active position is read
    function automatic logic [23:0] seq_rgb(input int p);
        return (act(p) && p < FT) ? 24'(vp(p) * HA + hp(p) + 1) : 24'h0;
    endfunction

    // Holds reset, loads the FIFO model, and releases reset at a negedge (cycle 0, h=v=0)
    task automatic do_reset(input logic en, input int words, input logic gaps);
        rst = 1'b1;
        enable = en;
        gap_en = gaps;
        underflow_clr = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 24'(i + 1);
        n_words = words;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 24'(i + 1);
        n_words = 32;
        repeat (3) @(negedge clk);
        checks++; if (video_hs !== 1'b0) begin errors++; $display("FAIL reset_hs got=%b exp=0", video_hs); end
        checks++; if (video_vs !== 1'b0) begin errors++; $display("FAIL reset_vs got=%b exp=0", video_vs); end
        checks++; if (video_de !== 1'b0) begin errors++; $display("FAIL reset_de got=%b exp=0", video_de); end
        checks++; if (video_rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb got=%h exp=000000", video_rgb); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_uf got=%b exp=0", underflow); end
    endtask

    task automatic test_idle();
        int p, line_de, total_de;
        line_de = 0;
        total_de = 0;
        do_reset(1'b0, 0, 1'b0);
        for (int k = 1; k <= 2 * FT + 2; k++) begin
            @(negedge clk);
            p = k - 3;
            checks++; if (video_de !== act(p)) begin errors++; $display("FAIL idle_de k=%0d got=%b exp=%b", k, video_de, act(p)); end
            checks++; if (video_hs !== hsx(p)) begin errors++; $display("FAIL idle_hs k=%0d got=%b exp=%b", k, video_hs, hsx(p)); end
            checks++; if (video_vs !== vsx(p)) begin errors++; $display("FAIL idle_vs k=%0d got=%b exp=%b", k, video_vs, vsx(p)); end
            checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en k=%0d got=%b exp=0", k, fifo_rd_en); end
            checks++; if (video_rgb !== 24'h0) begin errors++; $display("FAIL idle_rgb k=%0d got=%h exp=000000", k, video_rgb); end
            checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL idle_uf k=%0d got=%b exp=0", k, underflow); end
            if (p >= 0) begin
                line_de += int'(video_de);
                total_de += int'(video_de);
                if (hp(p) == HT - 1) begin
                    checks++;
                    if (line_de != ((vp(p) < VA) ? 8 : 0)) begin
                        errors++; $display("FAIL idle_line_de k=%0d got=%0d exp=%0d", k, line_de, (vp(p) < VA) ? 8 : 0);
                    end
                    line_de = 0;
                end
            end
        end
        checks++; if (total_de != 64) begin errors++; $display("FAIL idle_total_de got=%0d exp=64", total_de); end
    endtask

    task automatic test_stream();
        int p;
        do_reset(1'b1, 32, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            p = k - 3;
            checks++; if (video_rgb !== seq_rgb(p)) begin errors++; $display("FAIL stream_rgb k=%0d got=%h exp=%h", k, video_rgb, seq_rgb(p)); end
            checks++; if (video_de !== act(p)) begin errors++; $display("FAIL stream_de k=%0d got=%b exp=%b", k, video_de, act(p)); end
            checks++; if (frame_start !== (p == 0)) begin errors++; $display("FAIL stream_fs k=%0d got=%b exp=%b", k, frame_start, p == 0); end
            checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_uf k=%0d got=%b exp=0", k, underflow); end
            checks++; if (fifo_rd_en && fifo_rd_empty) begin errors++; $display("FAIL stream_rd_empty k=%0d got=1 exp=0", k); end
        end
        checks++; if (rd_ptr != 32) begin errors++; $display("FAIL stream_reads got=%0d exp=32", rd_ptr); end
    endtask

    task automatic test_underflow();
        int p;
        logic [23:0] exp_rgb;
        logic exp_uf;
        do_reset(1'b1, 5, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            p = k - 3;
            exp_rgb = (p >= 0 && p < 5) ? 24'(p + 1) : 24'h0;
            exp_uf = (k >= 8 && k <= 12) || k >= 17;
            checks++; if (video_rgb !== exp_rgb) begin errors++; $display("FAIL uf_rgb k=%0d got=%h exp=%h", k, video_rgb, exp_rgb); end
            checks++; if (video_de !== act(p)) begin errors++; $display("FAIL uf_de k=%0d got=%b exp=%b", k, video_de, act(p)); end
            checks++; if (underflow !== exp_uf) begin errors++; $display("FAIL uf_flag k=%0d got=%b exp=%b", k, underflow, exp_uf); end
            underflow_clr = (k == 12 || k == 16);
        end
        underflow_clr = 1'b0;
    endtask

    task automatic test_enable_drop();
        int p;
        do_reset(1'b1, 200, 1'b0);
        for (int k = 1; k <= 2 * FT + 2; k++) begin
            @(negedge clk);
            p = k - 3;
            checks++; if (video_rgb !== seq_rgb(p)) begin errors++; $display("FAIL drop_rgb k=%0d got=%h exp=%h", k, video_rgb, seq_rgb(p)); end
            checks++; if (frame_start !== (p == 0)) begin errors++; $display("FAIL drop_fs k=%0d got=%b exp=%b", k, frame_start, p == 0); end
            checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drop_uf k=%0d got=%b exp=0", k, underflow); end
            if (k >= FT) begin
                checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL drop_rd_en k=%0d got=%b exp=0", k, fifo_rd_en); end
            end
            if (k == FT - 1 || k == 2 * FT) begin
                checks++; if (rd_ptr != 32) begin errors++; $display("FAIL drop_reads k=%0d got=%0d exp=32", k, rd_ptr); end
            end
            if (k == 20) enable = 1'b0;
        end
    endtask

    task automatic test_gaps();
        int p;
        logic [23:0] exp_rgb;
        do_reset(1'b1, 200, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            p = k - 3;
            exp_rgb = (act(p) && p < FT && p % 2 == 0) ? 24'(vp(p) * 4 + hp(p) / 2 + 1) : 24'h0;
            checks++; if (fifo_rd_en && fifo_rd_empty) begin errors++; $display("FAIL gap_rd_empty k=%0d got=1 exp=0", k); end
            checks++; if (video_rgb !== exp_rgb) begin errors++; $display("FAIL gap_rgb k=%0d got=%h exp=%h", k, video_rgb, exp_rgb); end
            checks++; if (video_de !== act(p)) begin errors++; $display("FAIL gap_de k=%0d got=%b exp=%b", k, video_de, act(p)); end
        end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL gap_uf got=%b exp=1", underflow); end
    endtask

`ifdef HDMI_OUT_TEST_PATTERN_EN
    function automatic logic [23:0] bar_exp(input int i);
        return (i == 0) ? 24'hFFFFFF : (i == 1) ? 24'hFFFF00 : (i == 2) ? 24'h00FFFF : (i == 3) ? 24'h00FF00 :
               (i == 4) ? 24'hFF00FF : (i == 5) ? 24'hFF0000 : (i == 6) ? 24'h0000FF : 24'h000000;
    endfunction

    task automatic test_pattern();
        int p;
        logic [23:0] exp_rgb;
        pattern_sel = 1'b1;
        do_reset(1'b1, 32, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            p = k - 3;
            exp_rgb = act(p) ? bar_exp(hp(p)) : 24'h0;
            checks++; if (video_rgb !== exp_rgb) begin errors++; $display("FAIL pat_rgb k=%0d got=%h exp=%h", k, video_rgb, exp_rgb); end
            checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL pat_rd_en k=%0d got=%b exp=0", k, fifo_rd_en); end
            checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL pat_uf k=%0d got=%b exp=0", k, underflow); end
        end
        pattern_sel = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_stream();
        test_underflow();
        test_enable_drop();
        test_gaps();
`ifdef HDMI_OUT_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
